// File: rtl/fraise_result_collector.sv
// Per-class ones counter over a programmable window, sequential argmax scan, then
// write-out of counts and winner. Optional sticky interrupt under FRAISE_RESULT_IRQ_EN.
module fraise_result_collector #(
    parameter int unsigned NumClasses = 4,
    parameter int unsigned CountWidth = 8,
    parameter int unsigned DataWidth  = 32,
    parameter int unsigned AddrWidth  = 32,
    localparam int unsigned ArgW      = (NumClasses > 1) ? $clog2(NumClasses) : 1
) (
    input  logic                  clk_i,
    input  logic                  reset_n,
    input  logic                  start_i,
    input  logic [CountWidth-1:0] window_len_i,
    input  logic [AddrWidth-1:0]  result_ptr_i,
    input  logic                  bit_valid_i,
    input  logic [NumClasses-1:0] bit_i,
    output logic                  wr_valid_o,
    input  logic                  wr_ready_i,
    output logic [AddrWidth-1:0]  wr_addr_o,
    output logic [DataWidth-1:0]  wr_data_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ArgW-1:0]       argmax_o
`ifdef FRAISE_RESULT_IRQ_EN
    ,
    input  logic                  irq_clr_i,
    output logic                  irq_o
`endif
);
    localparam int unsigned IdxW = $clog2(NumClasses + 1);

    typedef enum logic [1:0] {IDLE, ACCUM, ARGMAX, WRITE} state_e;

    state_e                 state_q, state_d;
    logic [CountWidth-1:0]  len_q, len_d;
    logic [AddrWidth-1:0]   ptr_q, ptr_d;
    logic [CountWidth-1:0]  cnt_q [NumClasses];
    logic [CountWidth-1:0]  cnt_d [NumClasses];
    logic [CountWidth-1:0]  samp_q, samp_d;
    logic [IdxW-1:0]        idx_q, idx_d;
    logic [ArgW-1:0]        best_q, best_d;
    logic [CountWidth-1:0]  best_val_q, best_val_d;
    logic [ArgW-1:0]        argmax_q, argmax_d;

    logic [ArgW-1:0]        cls;
    logic [CountWidth-1:0]  samp_inc;
    logic                   scan_last, write_last, better, accept;

    assign cls        = idx_q[ArgW-1:0];
    assign samp_inc   = samp_q + CountWidth'(1);
    assign scan_last  = (idx_q == IdxW'(NumClasses - 1));
    assign write_last = (idx_q == IdxW'(NumClasses));
    // Index 0 seeds the scan; strict compare keeps the lowest index on ties.
    assign better     = (idx_q == '0) || (cnt_q[cls] > best_val_q);
    assign accept     = (state_q == WRITE) && wr_ready_i;

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_i) state_d = (window_len_i == '0) ? ARGMAX : ACCUM;
            ACCUM:   if (bit_valid_i && (samp_inc == len_q)) state_d = ARGMAX;
            ARGMAX:  if (scan_last) state_d = WRITE;
            WRITE:   if (accept && write_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_valid_o = (state_q == WRITE);
        busy_o     = (state_q != IDLE);
        done_o     = accept && write_last;
        wr_addr_o  = '0;
        wr_data_o  = '0;
        if (state_q == WRITE) begin
            wr_addr_o = ptr_q + AddrWidth'({idx_q, 2'b00});
            wr_data_o = write_last ? DataWidth'(argmax_q) : DataWidth'(cnt_q[cls]);
        end
    end

    assign argmax_o = argmax_q;

    always_comb begin
        len_d      = len_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        samp_d     = samp_q;
        idx_d      = idx_q;
        best_d     = best_q;
        best_val_d = best_val_q;
        argmax_d   = argmax_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    len_d  = window_len_i;
                    ptr_d  = result_ptr_i;
                    cnt_d  = '{default: '0};
                    samp_d = '0;
                    idx_d  = '0;
                end
            end
            ACCUM: begin
                if (bit_valid_i) begin
                    samp_d = samp_inc;
                    for (int unsigned i = 0; i < NumClasses; i++) begin
                        if (bit_i[i] && (cnt_q[i] != '1)) cnt_d[i] = cnt_q[i] + CountWidth'(1);
                    end
                end
            end
            ARGMAX: begin
                if (better) begin
                    best_d     = cls;
                    best_val_d = cnt_q[cls];
                end
                if (scan_last) begin
                    argmax_d = better ? cls : best_q;
                    idx_d    = '0;
                end else begin
                    idx_d = idx_q + IdxW'(1);
                end
            end
            WRITE: begin
                if (wr_ready_i && !write_last) idx_d = idx_q + IdxW'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            len_q      <= '0;
            ptr_q      <= '0;
            cnt_q      <= '{default: '0};
            samp_q     <= '0;
            idx_q      <= '0;
            best_q     <= '0;
            best_val_q <= '0;
            argmax_q   <= '0;
        end else begin
            len_q      <= len_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            samp_q     <= samp_d;
            idx_q      <= idx_d;
            best_q     <= best_d;
            best_val_q <= best_val_d;
            argmax_q   <= argmax_d;
        end
    end

`ifdef FRAISE_RESULT_IRQ_EN
    logic irq_q, irq_d;

    always_comb begin
        irq_d = irq_q;
        if (done_o)    irq_d = 1'b1;
        if (irq_clr_i) irq_d = 1'b0;
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) irq_q <= 1'b0;
        else          irq_q <= irq_d;
    end

    assign irq_o = irq_q;
`endif

endmodule

// File: doc/fraise_result_collector.md
Name: fraise_result_collector

Overview:
- Downstream stage of the fraise inference controller. Consumes the per-class stochastic `bit_out` stream produced by the Bayesian array during the averaging phase.
- Counts ones per class over a programmable window, then finds the winning class (argmax).
- Writes the per-class counts followed by the argmax word to memory at the result pointer, using a valid/ready write interface.
- Replaces the inline `result = result + bit_out` accumulation in the controller.

Parameters:
- NumClasses, 4: number of classes (matrix lines); width of `bit_i`.
- CountWidth, 8: width of each per-class counter and of the window length.
- DataWidth, 32: width of a write data word.
- AddrWidth, 32: width of a write address.

Ports:
- clk_i  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- start_i  in  1  single-cycle pulse; begins a new collection window.
- window_len_i  in  CountWidth  number of valid bit samples to accumulate; sampled on start.
- result_ptr_i  in  AddrWidth  base byte address for results; sampled on start.
- bit_valid_i  in  1  `bit_i` carries a valid sample this cycle.
- bit_i  in  NumClasses  one stochastic bit per class.
- wr_valid_o  out  1  write request valid.
- wr_ready_i  in  1  write request accepted.
- wr_addr_o  out  AddrWidth  write byte address.
- wr_data_o  out  DataWidth  write data.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  single-cycle pulse when the final write is accepted.
- argmax_o  out  $clog2(NumClasses) (min 1)  winner of the last completed window; held until the next window's ARGMAX phase completes.

Behaviour:
- Reset (async, `reset_n` = 0):
  - FSM goes to IDLE.
  - All counters are 0.
  - `wr_valid_o`, `busy_o`, `done_o` = 0; `wr_addr_o`, `wr_data_o`, `argmax_o` = 0.
  - Reset mid-operation aborts the window with no further writes.
- FSM states: IDLE, ACCUM, ARGMAX, WRITE.
- IDLE:
  - On `start_i`: latch `window_len_i` and `result_ptr_i`, clear all class counters and the sample counter.
  - Next state is ACCUM, or ARGMAX if `window_len_i` == 0.
- ACCUM:
  - Each cycle with `bit_valid_i`: counter[i] += `bit_i`[i] for every i; sample counter += 1.
  - Class counters saturate at 2^CountWidth-1; they never wrap.
  - When the sample counter reaches `window_len` (checked after the increment), go to ARGMAX the next cycle.
  - Samples with `bit_valid_i` low are ignored.
- ARGMAX:
  - Sequential scan, one class per cycle, index 0 to NumClasses-1; takes exactly NumClasses cycles.
  - Comparison is strict greater-than, so ties resolve to the lowest index.
  - `argmax_o` updates on the cycle the scan ends. Next state is WRITE.
- WRITE:
  - Emits NumClasses+1 words, in this order.
  - Word k (k < NumClasses): address = ptr + 4k, data = counter[k] zero-extended.
  - Word NumClasses: address = ptr + 4·NumClasses, data = argmax zero-extended.
  - Address arithmetic is modulo 2^AddrWidth.
  - `wr_valid_o` stays asserted, with address and data stable, until `wr_ready_i`. It may not drop or change before acceptance.
  - Back-to-back words are allowed: after acceptance, the next word is valid in the following cycle.
  - On acceptance of the last word: `done_o` = 1 for one cycle, next state IDLE.
- Simultaneous events:
  - `start_i` while `busy_o` is ignored (no restart, no latch).
  - `start_i` in the same cycle that `done_o` fires is ignored; the first accepted start is in IDLE.
  - `bit_valid_i` outside ACCUM is ignored.
- Latency with `wr_ready_i` tied high:
  - start → first `wr_valid_o` = 1 + (cycles to collect the window) + NumClasses.
  - Write phase = NumClasses+1 cycles.

Optional Feature:
- Macro: FRAISE_RESULT_IRQ_EN.
- When defined:
  - Adds output `irq_o` (1 bit) and input `irq_clr_i` (1 bit).
  - `irq_o` is set on the `done_o` cycle and stays sticky until `irq_clr_i` is sampled high.
  - Clear wins if clear and set happen in the same cycle.
  - Reset value 0.
- When undefined: ports absent; no interrupt logic.

Test Plan:
- NumClasses=4, len=8, ptr=0x2100; bit_i=4'b0011 for 8 valid cycles → writes (0x2100,8),(0x2104,8),(0x2108,0),(0x210C,0),(0x2110,0); argmax_o=0 (tie resolves low).
- len=5, bit_i pattern gives counts {1,4,2,0}; `bit_valid_i` low on alternate cycles → only valid samples counted; final word data=1; done_o pulses once.
- len=0 → no accumulation; five writes of all zeros at ptr..ptr+16; argmax 0.
- len=255 (CountWidth=8), bit_i=4'b1000 all cycles → counter[3]=255 with no wrap; argmax=3.
- wr_ready_i low for 3 cycles on each word → addr/data stable while wr_valid_o held; start_i pulsed during WRITE is ignored; exactly 5 writes.
- reset_n asserted mid-ACCUM → outputs 0 immediately; new start then full window → correct counts, no stale values.
